// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/halfword/word load-store with a fixed wait-state count.
// Optional macro DMEM_SIGN_EXT_EN enables sign extension of byte/halfword loads.
module data_mem_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              lsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       alu_rslt,
  input  logic              mem_reg,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [31:0]       wd3
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                access;
  logic                we_reg;
  logic [1:0]          size_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic                ack_reg, err_reg;
  logic [31:0]         rdata_reg;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         mem_q;
  logic [DEPTH_LOG2-1:0] idx_reg;
  logic                rd_en, mem_we;
  logic                out_of_range, access_err;
  logic [3:0]          lane_en;
  logic [31:0]         wlane;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_data;
  logic                sign_en;

  assign idx_reg = addr_reg[DEPTH_LOG2+1:2];

  generate
    if (ADDR_W > DEPTH_LOG2 + 2) begin : g_range
      assign out_of_range = |addr_reg[ADDR_W-1:DEPTH_LOG2+2];
    end else begin : g_norange
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign access_err = (size_reg == 2'b11)
                    | ((size_reg == 2'b01) & addr_reg[0])
                    | ((size_reg == 2'b10) & (addr_reg[1:0] != 2'b00))
                    | out_of_range;

  // Next-state and access strobe
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    access     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = WAIT;
          cnt_next   = WS;
        end
      end
      WAIT: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          access     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_en[gi] = (size_reg == 2'b10)
                         | ((size_reg == 2'b01) & (addr_reg[1] == 1'(gi / 2)))
                         | ((size_reg == 2'b00) & (addr_reg[1:0] == 2'(gi)));
    end
  endgenerate

  always_comb begin
    case (size_reg)
      2'b00:   wlane = {4{wdata_reg[7:0]}};
      2'b01:   wlane = {2{wdata_reg[15:0]}};
      default: wlane = wdata_reg;
    endcase
  end

`ifdef DMEM_SIGN_EXT_EN
  logic lsigned_reg;
  assign sign_en = lsigned_reg;
`else
  logic unused_lsigned;
  assign unused_lsigned = lsigned;
  assign sign_en        = 1'b0;
`endif

  assign ld_byte = mem_q[{addr_reg[1:0], 3'b000} +: 8];
  assign ld_half = mem_q[{addr_reg[1], 4'b0000} +: 16];

  always_comb begin
    case (size_reg)
      2'b00:   ld_data = {{24{sign_en & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{sign_en & ld_half[15]}}, ld_half};
      default: ld_data = mem_q;
    endcase
  end

  // Read the word at accept time so the access edge sees a registered RAM output.
  assign rd_en  = (state_reg == IDLE) & req;
  assign mem_we = access & we_reg & ~access_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx_reg][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
    if (rd_en) mem_q <= mem[addr[DEPTH_LOG2+1:2]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= 32'd0;
      we_reg    <= 1'b0;
      size_reg  <= 2'b00;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
`ifdef DMEM_SIGN_EXT_EN
      lsigned_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= access;
      err_reg   <= access & access_err;
      if (access & ~we_reg & ~access_err) rdata_reg <= ld_data;
      if (rd_en) begin
        we_reg    <= we;
        size_reg  <= size;
        addr_reg  <= addr;
        wdata_reg <= wdata;
`ifdef DMEM_SIGN_EXT_EN
        lsigned_reg <= lsigned;
`endif
      end
    end
  end

  assign busy  = (state_reg != IDLE);
  assign ack   = ack_reg;
  assign err   = err_reg;
  assign rdata = rdata_reg;
  assign wd3   = mem_reg ? rdata_reg : alu_rslt;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: vector table plus hand sequences for
// busy-ignore, reset abort and writeback mux behaviour.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, lsigned, mem_reg;
  logic [1:0]  size;
  logic [15:0] addr;
  logic [31:0] wdata, alu_rslt;
  logic        busy, ack, err;
  logic [31:0] rdata, wd3;

  int checks = 0;
  int errors = 0;

  localparam int LAT = 1 + 2;  // WAIT_STATES + 2

`ifdef DMEM_SIGN_EXT_EN
  localparam logic [31:0] SB80   = 32'hFFFFFF80;
  localparam logic [31:0] SH8001 = 32'hFFFF8001;
`else
  localparam logic [31:0] SB80   = 32'h00000080;
  localparam logic [31:0] SH8001 = 32'h00008001;
`endif

  data_mem_ctrl #(.ADDR_W(16), .DEPTH_LOG2(10), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .lsigned(lsigned),
    .addr(addr), .wdata(wdata), .alu_rslt(alu_rslt), .mem_reg(mem_reg),
    .busy(busy), .ack(ack), .err(err), .rdata(rdata), .wd3(wd3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        ls;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic t_we, input logic [1:0] t_size, input logic t_ls,
                         input logic [15:0] t_addr, input logic [31:0] t_wdata,
                         output int lat, output logic b1, output logic t_err,
                         output logic [31:0] t_rdata, output logic a2, output logic b2);
    @(posedge clk); #1;
    req = 1'b1; we = t_we; size = t_size; lsigned = t_ls; addr = t_addr; wdata = t_wdata;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    b1 = busy;
    while (!ack && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    t_err = err;
    t_rdata = rdata;
    @(posedge clk); #1;
    a2 = ack;
    b2 = busy;
  endtask

  initial begin
    int lat, acks;
    logic b1, a2, b2, e;
    logic [31:0] rd;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 16'h0004, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 16'h0004, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 16'h0006, 32'h00000080, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 16'h0006, 32'h0,        1'b0, SB80};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 16'h0004, 32'h0,        1'b0, 32'hDE80BEEF};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 16'h0003, 32'h0,        1'b1, 32'hDE80BEEF};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 16'h1000, 32'h0,        1'b1, 32'hDE80BEEF};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 16'h0000, 32'hCAFEF00D, 1'b0, 32'hDE80BEEF};
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 16'h1000, 32'h11111111, 1'b1, 32'hDE80BEEF};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 16'h0005, 32'h0000FFFF, 1'b1, 32'hDE80BEEF};
    vecs[10] = '{1'b1, 2'b11, 1'b0, 16'h0000, 32'h0,        1'b1, 32'hDE80BEEF};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 16'h0000, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 16'h0004, 32'h0,        1'b0, 32'hDE80BEEF};
    vecs[13] = '{1'b1, 2'b10, 1'b0, 16'h0008, 32'h24681357, 1'b0, 32'hDE80BEEF};
    vecs[14] = '{1'b1, 2'b01, 1'b0, 16'h000A, 32'hA5A58001, 1'b0, 32'hDE80BEEF};
    vecs[15] = '{1'b0, 2'b01, 1'b0, 16'h0008, 32'h0,        1'b0, 32'h00001357};
    vecs[16] = '{1'b0, 2'b00, 1'b1, 16'h0009, 32'h0,        1'b0, 32'h00000013};
    vecs[17] = '{1'b0, 2'b00, 1'b1, 16'h000B, 32'h0,        1'b0, SB80};
    vecs[18] = '{1'b0, 2'b01, 1'b1, 16'h000A, 32'h0,        1'b0, SH8001};
    vecs[19] = '{1'b0, 2'b10, 1'b0, 16'h0008, 32'h0,        1'b0, 32'h80011357};
    vecs[20] = '{1'b0, 2'b00, 1'b0, 16'h000B, 32'h0,        1'b0, 32'h00000080};
    vecs[21] = '{1'b0, 2'b11, 1'b0, 16'h0008, 32'h0,        1'b1, 32'h00000080};
    vecs[22] = '{1'b0, 2'b10, 1'b0, 16'h0002, 32'h0,        1'b1, 32'h00000080};

    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; lsigned = 1'b0;
    addr = 16'h0; wdata = 32'h0; alu_rslt = 32'h0; mem_reg = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      run_txn(vecs[i].we, vecs[i].size, vecs[i].ls, vecs[i].addr, vecs[i].wdata,
              lat, b1, e, rd, a2, b2);
      $display("txn %0d we=%0b size=%0d ls=%0b addr=%h wdata=%h -> lat=%0d err=%0b rdata=%h",
               i, vecs[i].we, vecs[i].size, vecs[i].ls, vecs[i].addr, vecs[i].wdata, lat, e, rd);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
      chk($sformatf("v%0d_busy", i), {31'd0, b1}, 32'd1);
      chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_ack_pulse", i), {31'd0, a2}, 32'd0);
      chk($sformatf("v%0d_idle", i), {31'd0, b2}, 32'd0);
    end

    // Writeback mux follows mem_reg combinationally.
    run_txn(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, lat, b1, e, rd, a2, b2);
    $display("txn st 0x0010 -> lat=%0d err=%0b", lat, e);
    run_txn(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, lat, b1, e, rd, a2, b2);
    $display("txn ld 0x0010 -> lat=%0d err=%0b rdata=%h", lat, e, rd);
    chk("wb_load_rdata", rd, 32'hDEADBEEF);
    alu_rslt = 32'h00000055; mem_reg = 1'b0; #1;
    chk("wd3_alu", wd3, 32'h00000055);
    mem_reg = 1'b1; #1;
    chk("wd3_mem", wd3, 32'hDEADBEEF);
    mem_reg = 1'b0; #1;
    chk("wd3_alu_again", wd3, 32'h00000055);

    // Request held through WAIT and DONE must not start a second access.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; size = 2'b10; lsigned = 1'b0; addr = 16'h0004;
    @(posedge clk); #1;
    addr = 16'h0000;
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    $display("txn busy-ignore ld 0x0004 -> acks=%0d rdata=%h", acks, rdata);
    chk("busy_ignore_acks", 32'(acks), 32'd1);
    chk("busy_ignore_rdata", rdata, 32'hDE80BEEF);
    chk("busy_ignore_idle", {31'd0, busy}, 32'd0);

    // Reset during WAIT aborts the store.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 16'h0008; wdata = 32'h12345678;
    @(posedge clk); #1;
    req = 1'b0;
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ack", {31'd0, ack}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    $display("txn st 0x0008 aborted by reset");
    run_txn(1'b0, 2'b10, 1'b0, 16'h0008, 32'h0, lat, b1, e, rd, a2, b2);
    $display("txn ld 0x0008 -> lat=%0d err=%0b rdata=%h", lat, e, rd);
    chk("abort_latency", 32'(lat), 32'(LAT));
    chk("abort_mem_kept", rd, 32'h80011357);
    chk("abort_err", {31'd0, e}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
